stereo_panner: RTL and testbench

//  Inverse of the two-input mixer: splits one mono sample into a left/right pair, each scaled by its own gain.

---
 rtl/stereo_panner_pkg.sv | 22 ++
 rtl/stereo_panner_q_mul_sat.sv | 60 ++++++
 rtl/stereo_panner.sv | 120 ++++++++++++
 tb/tb_stereo_panner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_panner_pkg.sv
// Shared fixed-point helpers and FSM state encoding for the panner (and the two-input mixer).
// Samples are Q0.(W-1) and gains are Q1.(W-2).
package stereo_panner_pkg;

    localparam int BITSIZE_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAP   = 2'd1,
        ST_MUL_L = 2'd2,
        ST_MUL_R = 2'd3
    } panner_state_t;

    function automatic int q_frac_sample(input int w);
        return w - 1;
    endfunction

    function automatic int q_frac_gain(input int w);
        return w - 2;
    endfunction

endpackage

// File: rtl/stereo_panner_q_mul_sat.sv
// One shared signed multiplier feeding two product registers, each followed by
// a shift back to sample scale and saturation with a clip flag.
module q_mul_sat
    import stereo_panner_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    input  logic               ld_l,
    input  logic               ld_r,
    output logic [BITSIZE-1:0] res_l,
    output logic               clip_l,
    output logic [BITSIZE-1:0] res_r,
    output logic               clip_r
);

    localparam int PW = 2 * BITSIZE;
    localparam int QG = q_frac_gain(BITSIZE);
    localparam logic signed [PW-1:0] SAT_MAX = {{(BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] p_l;
    logic signed [PW-1:0] p_r;

    assign a_ext = {{BITSIZE{a[BITSIZE-1]}}, a};
    assign b_ext = {{BITSIZE{b[BITSIZE-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_l <= '0;
            p_r <= '0;
        end else begin
            if (ld_l) p_l <= prod;
            if (ld_r) p_r <= prod;
        end
    end

    // Arithmetic shift truncates toward -inf; no rounding term is added.
    function automatic logic [BITSIZE:0] sat_fn(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> QG;
        if (s > SAT_MAX)
            sat_fn = {1'b1, SAT_MAX[BITSIZE-1:0]};
        else if (s < SAT_MIN)
            sat_fn = {1'b1, SAT_MIN[BITSIZE-1:0]};
        else
            sat_fn = {1'b0, s[BITSIZE-1:0]};
    endfunction

    assign {clip_l, res_l} = sat_fn(p_l);
    assign {clip_r, res_r} = sat_fn(p_r);

endmodule

// File: rtl/stereo_panner.sv
// Splits one mono sample into a gained left/right pair, once per lrclk frame,
// using a single time-shared multiplier sequenced on bclk.
module stereo_panner
    import stereo_panner_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF
) (
    input  logic               bclk,
    input  logic               rst_n,
    input  logic               lrclk,
    input  logic [BITSIZE-1:0] in,
    input  logic [BITSIZE-1:0] g_l,
    input  logic [BITSIZE-1:0] g_r,
    output logic [BITSIZE-1:0] out_l,
    output logic [BITSIZE-1:0] out_r,
    output logic               valid,
    output logic               clip_l,
    output logic               clip_r,
    output panner_state_t      fsm_state
);

    // valid is a one-cycle strobe with no ready: the consumer must take
    // out_l/out_r/clip_* in the cycle valid is high; there is no backpressure.

    panner_state_t      state;
    panner_state_t      state_nxt;
    logic               lrclk_d;
    logic               start;
    logic               cap_en;
    logic               ld_l;
    logic               ld_r;
    logic               out_en;
    logic [BITSIZE-1:0] in_q;
    logic [BITSIZE-1:0] gl_q;
    logic [BITSIZE-1:0] gr_q;
    logic [BITSIZE-1:0] mul_b;
    logic [BITSIZE-1:0] res_l;
    logic [BITSIZE-1:0] res_r;
    logic               sat_l;
    logic               sat_r;

    assign start     = lrclk & ~lrclk_d;
    assign fsm_state = state;

    // A rising lrclk in any state restarts the frame, discarding work in flight.
    always_comb begin
        state_nxt = state;
        cap_en    = start;
        ld_l      = 1'b0;
        ld_r      = 1'b0;
        out_en    = 1'b0;
        mul_b     = gr_q;
        if (start) begin
            state_nxt = ST_CAP;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_CAP: begin
                    ld_l      = 1'b1;
                    mul_b     = gl_q;
                    state_nxt = ST_MUL_L;
                end
                ST_MUL_L: begin
                    ld_r      = 1'b1;
                    state_nxt = ST_MUL_R;
                end
                ST_MUL_R: begin
                    out_en    = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // lrclk_d resets high so an lrclk already high at release is not a frame start.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lrclk_d <= 1'b1;
            in_q    <= '0;
            gl_q    <= '0;
            gr_q    <= '0;
            out_l   <= '0;
            out_r   <= '0;
            clip_l  <= 1'b0;
            clip_r  <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= state_nxt;
            lrclk_d <= lrclk;
            valid   <= out_en;
            if (cap_en) begin
                in_q <= in;
                gl_q <= g_l;
                gr_q <= g_r;
            end
            if (out_en) begin
                out_l  <= res_l;
                out_r  <= res_r;
                clip_l <= sat_l;
                clip_r <= sat_r;
            end
        end
    end

    q_mul_sat #(.BITSIZE(BITSIZE)) u_mul (
        .clk    (bclk),
        .rst_n  (rst_n),
        .a      (in_q),
        .b      (mul_b),
        .ld_l   (ld_l),
        .ld_r   (ld_r),
        .res_l  (res_l),
        .clip_l (sat_l),
        .res_r  (res_r),
        .clip_r (sat_r)
    );

endmodule

// File: tb/tb_stereo_panner.sv
// Self-checking bench for stereo_panner: fixed vector table, random frames
// against an integer reference model, and restart/reset corner sequences.
module tb_stereo_panner;
    import stereo_panner_pkg::*;

    logic          bclk;
    logic          rst_n;
    logic          lrclk;
    logic [15:0]   din;
    logic [15:0]   gl;
    logic [15:0]   gr;
    logic [15:0]   out_l;
    logic [15:0]   out_r;
    logic          valid;
    logic          clip_l;
    logic          clip_r;
    panner_state_t fsm_state;

    int tests;
    int fails;

    typedef struct {
        logic [15:0] x;
        logic [15:0] gl;
        logic [15:0] gr;
        logic [15:0] el;
        logic [15:0] er;
        logic        cl;
        logic        cr;
    } vec_t;

    vec_t vecs[8];

    stereo_panner #(.BITSIZE(16)) dut (
        .bclk      (bclk),
        .rst_n     (rst_n),
        .lrclk     (lrclk),
        .in        (din),
        .g_l       (gl),
        .g_r       (gr),
        .out_l     (out_l),
        .out_r     (out_r),
        .valid     (valid),
        .clip_l    (clip_l),
        .clip_r    (clip_r),
        .fsm_state (fsm_state)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, floor division by 2^14, clamp to 16-bit range.
    function automatic void model(input logic [15:0] x, input logic [15:0] g,
                                  output logic [15:0] r, output logic c);
        longint p;
        longint s;
        p = longint'($signed(x)) * longint'($signed(g));
        s = p / 16384;
        if ((p % 16384 != 0) && (p < 0)) s = s - 1;
        if (s > 32767) begin
            r = 16'h7fff;
            c = 1'b1;
        end else if (s < -32768) begin
            r = 16'h8000;
            c = 1'b1;
        end else begin
            r = s[15:0];
            c = 1'b0;
        end
    endfunction

    task automatic tick;
        @(posedge bclk);
        #1;
    endtask

    // One full lrclk frame (32 high, 33 low). Inputs are scrambled after edge k
    // so only the captured values can produce the expected result.
    task automatic run_frame(input string name, input vec_t v);
        int vbad;
        vbad = 0;
        @(negedge bclk);
        din   = v.x;
        gl    = v.gl;
        gr    = v.gr;
        lrclk = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (valid !== (i == 3)) vbad++;
            if (i == 3) begin
                check({name, " out_l"}, {16'h0, out_l}, {16'h0, v.el});
                check({name, " out_r"}, {16'h0, out_r}, {16'h0, v.er});
                check({name, " clip"}, {30'h0, clip_l, clip_r}, {30'h0, v.cl, v.cr});
            end
            @(negedge bclk);
            if (i == 0) begin
                din = 16'($urandom);
                gl  = 16'($urandom);
                gr  = 16'($urandom);
            end
            lrclk = (i < 31);
        end
        check({name, " valid_pulse"}, vbad, 0);
        check({name, " hold"}, {out_l, out_r}, {v.el, v.er});
    endtask

    initial begin
        vec_t v;
        int   vbad;
        tests = 0;
        fails = 0;

        vecs[0] = '{16'h1000, 16'h4000, 16'h2000, 16'h1000, 16'h0800, 1'b0, 1'b0};
        vecs[1] = '{16'hc000, 16'h4000, 16'hc000, 16'hc000, 16'h4000, 1'b0, 1'b0};
        vecs[2] = '{16'h7fff, 16'h7fff, 16'h4000, 16'h7fff, 16'h7fff, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h4000, 16'h8000, 16'h8000, 16'h7fff, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 16'h2000, 16'h4000, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hffff, 16'h4000, 16'h2000, 16'hffff, 16'hffff, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h4001, 16'hc000, 16'h8000, 16'h7fff, 1'b1, 1'b1};
        vecs[7] = '{16'h7fff, 16'hc000, 16'h0000, 16'h8001, 16'h0000, 1'b0, 1'b0};

        // Reset with lrclk already high: release must not start a frame.
        rst_n = 1'b0;
        lrclk = 1'b1;
        din   = 16'h1234;
        gl    = 16'h4000;
        gr    = 16'h4000;
        repeat (3) tick();
        check("reset outputs", {out_l, out_r}, 32'h0);
        check("reset flags", {29'h0, valid, clip_l, clip_r}, 32'h0);
        check("reset state", {30'h0, fsm_state}, {30'h0, ST_IDLE});
        @(negedge bclk);
        rst_n = 1'b1;
        vbad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid !== 1'b0 || fsm_state !== ST_IDLE) vbad++;
        end
        check("no frame on high release", vbad, 0);
        @(negedge bclk);
        lrclk = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 30; i++) begin
            v.x  = 16'($urandom);
            v.gl = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
            v.gr = (i % 7 == 0) ? 16'h7fff : 16'($urandom_range(0, 16'hffff));
            if (i % 3 == 0) v.x = (i % 2 == 0) ? 16'h8000 : 16'h7fff;
            model(v.x, v.gl, v.el, v.cl);
            model(v.x, v.gr, v.er, v.cr);
            run_frame($sformatf("rand%0d", i), v);
        end

        // Restart: second lrclk rise lands on edge k+2.
        vbad = 0;
        @(negedge bclk);
        din = 16'h2000; gl = 16'h4000; gr = 16'h4000; lrclk = 1'b1;
        tick();                                  // edge k
        if (valid !== 1'b0) vbad++;
        @(negedge bclk);
        lrclk = 1'b0;
        tick();                                  // edge k+1
        if (valid !== 1'b0) vbad++;
        @(negedge bclk);
        din = 16'h0100; gl = 16'h4000; gr = 16'h2000; lrclk = 1'b1;
        tick();                                  // edge k+2 = k'
        if (valid !== 1'b0) vbad++;
        @(negedge bclk);
        din = 16'h7777; gl = 16'h1111; gr = 16'h2222;
        tick();                                  // k+3 = k'+1
        if (valid !== 1'b0) vbad++;
        tick();                                  // k'+2
        if (valid !== 1'b0) vbad++;
        check("restart no early valid", vbad, 0);
        tick();                                  // k'+3
        check("restart valid", {31'h0, valid}, 32'h1);
        check("restart result", {out_l, out_r}, {16'h0100, 16'h0080});
        check("restart clip", {30'h0, clip_l, clip_r}, 32'h0);
        tick();
        check("restart valid drop", {31'h0, valid}, 32'h0);
        @(negedge bclk);
        lrclk = 1'b0;
        repeat (4) tick();

        // Reset mid-frame between edges k+1 and k+2, released with lrclk high.
        @(negedge bclk);
        din = 16'h4000; gl = 16'h4000; gr = 16'h4000; lrclk = 1'b1;
        tick();                                  // edge k
        tick();                                  // edge k+1
        @(negedge bclk);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {out_l, out_r}, 32'h0);
        check("async reset flags", {29'h0, valid, clip_l, clip_r}, 32'h0);
        vbad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid !== 1'b0) vbad++;
        end
        @(negedge bclk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid !== 1'b0 || fsm_state !== ST_IDLE) vbad++;
        end
        check("no valid after mid-frame reset", vbad, 0);
        @(negedge bclk);
        lrclk = 1'b0;
        repeat (4) tick();
        run_frame("post-reset", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
